dut_bus_arbiter: RTL and testbench
==================================

# dut_bus_arbiter

Round-robin arbiter sharing one signed DATA_WIDTH-bit DUT input channel among BUS_WIDTH requesters. Sits between the stimulus sources and the DUT's in3 port: accepts one word per cycle from the winning requester via valid/ready, registers it, and presents it with the source ID on a single output channel held stable until the downstream accepts it.

## Interface
- DATA_WIDTH, 4, width of each signed data word
- BUS_WIDTH, 2, number of requesters (≥1)
- ID_WIDTH, derived: $clog2(BUS_WIDTH), minimum 1; not user-set
- CNT_WIDTH, 8, width of each grant counter (used only with DUT_ARB_STATS_EN)

Ports:
- clk1  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1 x [BUS_WIDTH-1:0] unpacked  requester i has a word
- req_data  in  signed [DATA_WIDTH-1:0] x [BUS_WIDTH-1:0] unpacked  requester words
- req_ready  out  1 x [BUS_WIDTH-1:0] unpacked  word of requester i accepted this cycle
- out_valid  out  1  out_data/out_id hold a word
- out_data  out  signed [DATA_WIDTH-1:0]  granted word, to DUT in3
- out_id  out  [ID_WIDTH-1:0]  index of requester that supplied out_data
- out_ready  in  1  downstream accepts word when out_valid & out_ready
- grant_cnt  out  [CNT_WIDTH-1:0] x [BUS_WIDTH-1:0] unpacked  per-requester grant count (only with DUT_ARB_STATS_EN)

## Operation
- Two-state FSM on the output register: EMPTY (out_valid=0), FULL (out_valid=1).
- can_load = (state==EMPTY) | (out_valid & out_ready).
- Arbitration, combinational: search requesters starting at last+1 mod BUS_WIDTH, wrapping; first with req_valid=1 wins. `last` is the register holding the previous winner.
- req_ready[i]=1 only for the winner, only when can_load; all others 0. req_ready never asserts for a requester with req_valid=0.
- On a grant (winner exists & can_load): out_data<=req_data[winner], out_id<=winner, out_valid<=1, last<=winner; state FULL.
- On a drain with no grant: out_valid<=0; state EMPTY. out_data/out_id keep their last values.
- FULL & out_ready=0: out_valid, out_data and out_id are held stable. No req_ready asserts.
- Simultaneous drain and grant: new word loads in the same cycle, so out_valid stays 1. This gives one word per cycle sustained.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,BUS_WIDTH-1,0,… No requester waits more than BUS_WIDTH-1 grants.
- BUS_WIDTH=1: always grants requester 0; out_id=0.
- Data passes unmodified; no sign extension or truncation.

## Timing
- Reset values (rst=1 at a clock edge): out_valid=0, out_data=0, out_id=0, last=BUS_WIDTH-1 (so requester 0 has first priority), state EMPTY, grant_cnt all 0.
- req_ready is 0 for every requester while rst=1.
- Reset mid-transfer discards any held word. The first cycle after rst deasserts behaves as EMPTY.
- Latency: word accepted at edge N appears on out_data with out_valid=1 after edge N (registered, 1 cycle).
- req_ready depends combinationally on req_valid, out_valid and out_ready. There is no combinational path from req_data to the outputs.
- The handshake completes at the edge where valid & ready are both 1. Requesters hold req_data stable while req_valid=1 and req_ready=0.

## Configuration
- Macro: DUT_ARB_STATS_EN.
- Defined: port grant_cnt exists. grant_cnt[i] increments by 1 on every grant to requester i and saturates at 2^CNT_WIDTH-1 (it does not wrap). Reset clears it to 0.
- Undefined: grant_cnt port and its counters are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst=1 with all req_valid=1 → req_ready all 0, out_valid=0, out_data=0, out_id=0. After release, first grant goes to requester 0.
- Round-robin: BUS_WIDTH=2, both valid continuously, req_data0=3, req_data1=-5, out_ready=1 → out_id sequence 0,1,0,1; out_data 3,-5,3,-5; out_valid=1 every cycle after the first.
- Backpressure: out_ready=0 for 4 cycles holding word -8 (id 1) → out_data=-8 and out_id=1 stable, req_ready all 0. When out_ready returns to 1, the next word loads in that same cycle.
- Single requester and wrap: only requester 1 valid, value 7 → repeated grants to 1 and req_ready[0] stays 0. Then requester 0 joins → it wins the next grant.
- Idle drain: one word -1 from requester 0, then no valid inputs, out_ready=1 → out_valid is 1 for exactly one cycle, then 0. out_data keeps -1.
- Stats (DUT_ARB_STATS_EN, CNT_WIDTH=2): 5 grants to requester 0 → grant_cnt[0]=3 (saturated), grant_cnt[1]=0. Then rst → both 0.

Source files
------------

// File: rtl/dut_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dut_bus_arbiter
//
// Round-robin arbiter that shares one signed DATA_WIDTH-bit channel (the
// DUT's in3 input) among BUS_WIDTH requesters. One word per cycle is taken
// from the winning requester over valid/ready, registered, and presented
// with its source index until the downstream side accepts it.
//
// Parameters:
//   DATA_WIDTH  width of each signed data word
//   BUS_WIDTH   number of requesters (>= 1)
//   CNT_WIDTH   width of each grant counter (statistics build only)
//   ID_WIDTH    derived source-index width, at least 1
//
// Ports:
//   clk1        clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   req_valid   per requester: a word is offered
//   req_data    per requester: the offered signed word
//   req_ready   per requester: the offered word is taken this cycle
//   out_valid   out_data/out_id hold a word
//   out_data    granted word
//   out_id      index of the requester that supplied out_data
//   out_ready   downstream takes the word when out_valid & out_ready
//   grant_cnt   per requester saturating grant count (DUT_ARB_STATS_EN only)
//
// Optional feature: define DUT_ARB_STATS_EN to add the grant_cnt port and
// its counters. Without it the arbiter is otherwise identical.
// ---------------------------------------------------------------------------
module dut_bus_arbiter #(
    parameter  int DATA_WIDTH = 4,
    parameter  int BUS_WIDTH  = 2,
    parameter  int CNT_WIDTH  = 8,
    localparam int ID_WIDTH   = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         req_valid [BUS_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] req_data  [BUS_WIDTH],
    output logic                         req_ready [BUS_WIDTH],
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic        [ID_WIDTH-1:0]   out_id,
    input  logic                         out_ready
`ifdef DUT_ARB_STATS_EN
    ,
    output logic        [CNT_WIDTH-1:0]  grant_cnt [BUS_WIDTH]
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] last;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] cand;
    logic                winner_found;
    logic                can_load;
    logic                grant;

    // Round-robin search starting just after the previous winner and
    // wrapping; the first requester found with a valid word wins.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        cand         = '0;
        for (int k = 1; k <= BUS_WIDTH; k++) begin
            cand = ID_WIDTH'((int'(last) + k) % BUS_WIDTH);
            if (!winner_found && req_valid[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    // The output register may load when it is empty or is being drained in
    // this same cycle, which is what sustains one word per cycle. Reset
    // suppresses every grant so no requester sees ready while rst is high.
    always_comb begin
        can_load = (state == EMPTY) || (out_valid && out_ready);
        grant    = winner_found && can_load && !rst;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            req_ready[i] = grant && (winner == ID_WIDTH'(i));
        end
    end

    // Output register FSM. A grant always wins over a plain drain, so a
    // simultaneous drain and grant keeps out_valid high. A drain without a
    // grant only clears out_valid; data and id keep their last values.
    // last resets to the top index so requester 0 has first priority.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            last      <= ID_WIDTH'(BUS_WIDTH - 1);
        end else if (grant) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= req_data[winner];
            out_id    <= winner;
            last      <= winner;
        end else if (out_valid && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end
    end

`ifdef DUT_ARB_STATS_EN
    // Per-requester grant counters that stop at all-ones instead of wrapping.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (rst) begin
                grant_cnt[i] <= '0;
            end else if (req_ready[i] && (grant_cnt[i] != {CNT_WIDTH{1'b1}})) begin
                grant_cnt[i] <= grant_cnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dut_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dut_bus_arbiter
//
// Self-checking bench for dut_bus_arbiter with two requesters and 4-bit data.
// Requesters are modelled as single-word sources that are refilled either
// from a directed value or randomly. A reference model decides, from the
// round-robin rule and the output slot occupancy, which requester should be
// granted each cycle; every predicted grant is pushed into a scoreboard and
// a separate monitor pops and compares whenever a word leaves the arbiter.
// With DUT_ARB_STATS_EN defined the bench also tracks grant counts
// (CNT_WIDTH=2, saturating at 3).
// ---------------------------------------------------------------------------
module tb_dut_bus_arbiter;

    localparam int DW   = 4;
    localparam int BW   = 2;
    localparam int CW   = 2;
    localparam int ID_W = 1;

    logic                 clk1 = 1'b0;
    logic                 rst;
    logic                 req_valid [BW];
    logic signed [DW-1:0] req_data  [BW];
    logic                 req_ready [BW];
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_ready;
`ifdef DUT_ARB_STATS_EN
    logic [CW-1:0]        grant_cnt [BW];
`endif

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Requester sources and their refill policy.
    bit  has_word [BW];
    int  word_val [BW];
    bit  feed_en  [BW];
    int  feed_val [BW];
    bit  rand_mode;

    // Reference model state: output slot occupied, previous winner, counts.
    bit  m_full;
    int  m_last;
    int  m_cnt [BW];

    dut_bus_arbiter #(
        .DATA_WIDTH(DW),
        .BUS_WIDTH (BW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk1     (clk1),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_ready(out_ready)
`ifdef DUT_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    // One comparison: counts it and reports any difference.
    task automatic compare(input string name, input logic signed [31:0] actual,
                           input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive reset, requester words and out_ready at the falling edge.
    task automatic applyStimulus(input bit r, input bit ready);
        @(negedge clk1);
        rst = r;
        for (int i = 0; i < BW; i++) begin
            if (!has_word[i]) begin
                if (rand_mode) begin
                    if ($urandom_range(0, 2) != 0) begin
                        has_word[i] = 1'b1;
                        word_val[i] = int'($urandom_range(0, 15)) - 8;
                    end
                end else if (feed_en[i]) begin
                    has_word[i] = 1'b1;
                    word_val[i] = feed_val[i];
                end
            end
            req_valid[i] = has_word[i];
            req_data[i]  = has_word[i] ? DW'(word_val[i]) : DW'($urandom);
        end
        out_ready = ready;
    endtask

    // Compare the present outputs with the model, then advance the model to
    // what the coming rising edge should do.
    task automatic checkOutput();
        int  win;
        bit  can_load;
        bit  grant;
        int  idx;
        #1;
        compare("out_valid", out_valid, m_full);
`ifdef DUT_ARB_STATS_EN
        for (int i = 0; i < BW; i++) begin
            compare($sformatf("grant_cnt%0d", i), grant_cnt[i], m_cnt[i]);
        end
`endif
        win = -1;
        for (int k = 1; k <= BW; k++) begin
            idx = (m_last + k) % BW;
            if (win < 0 && has_word[idx]) win = idx;
        end
        can_load = !m_full || out_ready;
        grant    = !rst && (win >= 0) && can_load;
        for (int i = 0; i < BW; i++) begin
            compare($sformatf("req_ready%0d", i), req_ready[i], grant && (win == i));
        end
        if (rst) begin
            m_full = 1'b0;
            m_last = BW - 1;
            sb.delete();
            for (int i = 0; i < BW; i++) m_cnt[i] = 0;
        end else if (grant) begin
            sb.push_back('{id: win, data: word_val[win]});
            has_word[win] = 1'b0;
            m_full = 1'b1;
            m_last = win;
            if (m_cnt[win] < (1 << CW) - 1) m_cnt[win]++;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic cycle(input bit r, input bit ready);
        applyStimulus(r, ready);
        checkOutput();
    endtask

    task automatic feedsOff();
        for (int i = 0; i < BW; i++) feed_en[i] = 1'b0;
    endtask

    // Monitor: a word leaves at the next rising edge when out_valid and
    // out_ready are both high; compare it against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk1);
            #2;
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got id %0d data %0d expected no word",
                             out_id, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    compare("sb_id", out_id, mon_e.id);
                    compare("sb_data", out_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        rand_mode = 1'b0;
        m_full    = 1'b0;
        m_last    = BW - 1;
        for (int i = 0; i < BW; i++) begin
            has_word[i]  = 1'b0;
            word_val[i]  = 0;
            feed_en[i]   = 1'b1;
            feed_val[i]  = i + 1;
            m_cnt[i]     = 0;
            req_valid[i] = 1'b1;
            req_data[i]  = '0;
        end
        repeat (2) @(posedge clk1);

        // Reset with every requester valid: no ready, cleared outputs.
        cycle(1'b1, 1'b1);
        compare("rst_out_data", out_data, 0);
        compare("rst_out_id", out_id, 0);

        // Round robin with 3 and -5; first grant after reset goes to 0.
        for (int i = 0; i < BW; i++) has_word[i] = 1'b0;
        feed_val[0] = 3;
        feed_val[1] = -5;
        cycle(1'b0, 1'b1);
        repeat (6) cycle(1'b0, 1'b1);
        feedsOff();
        repeat (4) cycle(1'b0, 1'b1);

        // Backpressure holding -8 from requester 1, then same-cycle reload.
        feed_en[1]  = 1'b1;
        feed_val[1] = -8;
        cycle(1'b0, 1'b1);
        feed_en[1]  = 1'b0;
        feed_en[0]  = 1'b1;
        feed_val[0] = 2;
        repeat (4) begin
            cycle(1'b0, 1'b0);
            compare("hold_data", out_data, -8);
            compare("hold_id", out_id, 1);
        end
        cycle(1'b0, 1'b1);
        feedsOff();
        repeat (4) cycle(1'b0, 1'b1);

        // Only requester 1 valid, then requester 0 joins and wins next.
        feed_en[1]  = 1'b1;
        feed_val[1] = 7;
        repeat (4) cycle(1'b0, 1'b1);
        feed_en[0]  = 1'b1;
        feed_val[0] = 6;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        compare("join_win_id", out_id, 0);
        feedsOff();
        repeat (4) cycle(1'b0, 1'b1);

        // Idle drain of a single -1: valid for exactly one cycle.
        feed_en[0]  = 1'b1;
        feed_val[0] = -1;
        cycle(1'b0, 1'b1);
        feed_en[0]  = 1'b0;
        cycle(1'b0, 1'b1);
        compare("drain_valid_hi", out_valid, 1);
        cycle(1'b0, 1'b1);
        compare("drain_valid_lo", out_valid, 0);
        compare("drain_keep_data", out_data, -1);

        // Five grants to requester 0 only, then reset clears the counts.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < BW; i++) has_word[i] = 1'b0;
        feed_en[0]  = 1'b1;
        feed_val[0] = 4;
        repeat (5) cycle(1'b0, 1'b1);
        feedsOff();
        repeat (3) cycle(1'b0, 1'b1);
`ifdef DUT_ARB_STATS_EN
        compare("stat_cnt0_sat", grant_cnt[0], 3);
        compare("stat_cnt1_zero", grant_cnt[1], 0);
`endif
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
`ifdef DUT_ARB_STATS_EN
        compare("stat_rst_cnt0", grant_cnt[0], 0);
        compare("stat_rst_cnt1", grant_cnt[1], 0);
`endif

        // Reset while a word is held discards it.
        feed_en[0] = 1'b1;
        feed_en[1] = 1'b1;
        repeat (2) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < BW; i++) has_word[i] = 1'b0;
        feedsOff();
        cycle(1'b0, 1'b1);
        compare("midrst_empty", out_valid, 0);

        // Randomized traffic, backpressure and occasional reset.
        rand_mode = 1'b1;
        repeat (400) cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        rand_mode = 1'b0;
        repeat (6) cycle(1'b0, 1'b1);

        @(negedge clk1);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
